// File: rtl/mem_dmem_ctrl.sv
// MEM-stage data-memory controller: one request per load/store, stalls the pipeline
// until the memory responds, then presents lane-extracted load data for one cycle.
//
// state | meaning
// IDLE  | waiting for an aligned access; stall/misaligned decoded from inputs
// REQ   | request on the bus, held stable until dmem_resp
// DONE  | one-cycle completion, stall released, load_valid for loads
module mem_dmem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_mem_wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_lane;
  logic [31:0] w_load_ext;

  logic        r_dmem_read;
  logic        r_dmem_write;
  logic [31:0] r_address;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_load_data;
  logic        r_load_valid;

  assign w_mem_op = mem_valid & (mem_read | mem_write);

  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b0000;
    case (mem_funct3[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << mem_alu_out[1:0];
      end
      2'b01: begin
        w_aligned = ~mem_alu_out[0];
        w_be      = 4'b0011 << {mem_alu_out[1], 1'b0};
      end
      default: begin
        w_aligned = (mem_alu_out[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
    endcase
    // Byte enables mark store lanes only; loads fetch the whole word.
    if (!mem_write) w_be = 4'b0000;
  end

  assign w_access   = w_mem_op & w_aligned;
  assign w_wdata_sh = mem_mem_wdata << {mem_alu_out[1:0], 3'b000};
  assign w_lane     = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
      3'b101:  w_load_ext = {16'h0000, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    misaligned  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall      = w_access;
        misaligned = w_mem_op & ~w_aligned;
        if (w_access) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dmem_resp) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read/write together is a store, so the read strobe needs mem_write low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_read  <= 1'b0;
      r_dmem_write <= 1'b0;
      r_address    <= 32'h0;
      r_be         <= 4'h0;
      r_wdata      <= 32'h0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= (r_state == ST_REQ) && dmem_resp && r_dmem_read;
      if (r_state == ST_IDLE && w_access) begin
        r_dmem_read  <= ~mem_write;
        r_dmem_write <= mem_write;
        r_address    <= {mem_alu_out[31:2], 2'b00};
        r_be         <= w_be;
        r_wdata      <= w_wdata_sh;
        r_funct3     <= mem_funct3;
        r_off        <= mem_alu_out[1:0];
      end else if (r_state == ST_REQ && dmem_resp) begin
        r_dmem_read  <= 1'b0;
        r_dmem_write <= 1'b0;
        if (r_dmem_read) r_load_data <= w_load_ext;
      end
    end
  end

  assign dmem_read        = r_dmem_read;
  assign dmem_write       = r_dmem_write;
  assign dmem_address     = r_address;
  assign dmem_byte_enable = r_be;
  assign dmem_wdata       = r_wdata;
  assign load_data        = r_load_data;
  assign load_valid       = r_load_valid;

endmodule

// File: tb/tb_mem_dmem_ctrl.sv
// Bench for mem_dmem_ctrl: directed vector table, reset-abandon sequence and
// randomized transactions checked cycle by cycle against a transaction-level model.
module tb_mem_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_out, mem_mem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;

  int n_chk  = 0;
  int n_fail = 0;

  mem_dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_alu_out(mem_alu_out), .mem_mem_wdata(mem_mem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        e_mis, e_req, e_isload;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_ld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, rd, wr, input logic [2:0] f3,
                              input logic [31:0] addr, wdata, rdata, input int waits,
                              input logic e_mis, e_req, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata, e_ld);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.e_mis = e_mis; v.e_req = e_req; v.e_isload = rd & ~wr;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_ld = e_ld;
    return v;
  endfunction

  // Reference: sizes/offsets turned into plain arithmetic on byte counts.
  function automatic vec_t model(input logic valid, rd, wr, input logic [2:0] f3,
                                 input logic [31:0] addr, wdata, rdata, input int waits);
    vec_t v;
    int nb, off;
    logic [63:0] tmp, lim;
    logic memop, aligned;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    aligned = (off % nb) == 0;
    memop   = valid && (rd || wr);
    v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.e_mis = memop && !aligned;
    v.e_req = memop && aligned;
    v.e_isload = rd && !wr;
    v.e_addr = addr - 32'(off);
    v.e_be = 4'(((1 << nb) - 1) << off);
    tmp = 64'(wdata) << (8 * off);
    v.e_wdata = tmp[31:0];
    tmp = 64'(rdata) >> (8 * off);
    if (nb < 4) begin
      lim = 64'd1 << (8 * nb);
      tmp = tmp % lim;
      if (!f3[2] && tmp >= lim / 2) tmp = tmp + 64'h1_0000_0000 - lim;
    end
    v.e_ld = tmp[31:0];
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input logic stray);
    @(negedge clk);
    mem_valid = v.valid; mem_read = v.rd; mem_write = v.wr; mem_funct3 = v.f3;
    mem_alu_out = v.addr; mem_mem_wdata = v.wdata;
    dmem_resp = stray; dmem_rdata = $urandom;
    #1;
    chk("idle_misaligned", 32'(misaligned), 32'(v.e_mis));
    chk("idle_stall", 32'(stall), 32'(v.e_req));
    chk("idle_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("idle_load_valid", 32'(load_valid), 32'd0);
    if (v.e_req) begin
      for (int i = 0; i <= v.waits; i++) begin
        @(negedge clk);
        dmem_resp  = (i == v.waits);
        dmem_rdata = (i == v.waits) ? v.rdata : $urandom;
        #1;
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_read", 32'(dmem_read), 32'(v.e_isload));
        chk("req_write", 32'(dmem_write), 32'(!v.e_isload));
        chk("req_addr", dmem_address, v.e_addr);
        chk("req_misaligned", 32'(misaligned), 32'd0);
        if (!v.e_isload) begin
          chk("req_be", 32'(dmem_byte_enable), 32'(v.e_be));
          chk("req_wdata", dmem_wdata, v.e_wdata);
        end
      end
      @(negedge clk);
      dmem_resp = stray; dmem_rdata = $urandom;
      #1;
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
      chk("done_load_valid", 32'(load_valid), 32'(v.e_isload));
      if (v.e_isload) chk("done_load_data", load_data, v.e_ld);
    end
  endtask

  vec_t tbl[12];
  logic [2:0] f3_ld [5];
  logic [2:0] f3_st [3];

  initial begin
    tbl[0]  = mk(1,1,0,3'b000,32'h1003,32'h0,32'h80FF_FF12,2, 0,1,32'h1000,4'h0,32'h0,32'hFFFF_FF80);
    tbl[1]  = mk(1,0,1,3'b001,32'h2002,32'h0000_BEEF,32'h0,0, 0,1,32'h2000,4'b1100,32'hBEEF_0000,32'h0);
    tbl[2]  = mk(1,1,0,3'b010,32'h3001,32'h0,32'h0,0, 1,0,32'h0,4'h0,32'h0,32'h0);
    tbl[3]  = mk(1,1,0,3'b101,32'h3002,32'h0,32'h8001_0000,1, 0,1,32'h3000,4'h0,32'h0,32'h0000_8001);
    tbl[4]  = mk(1,1,0,3'b010,32'h4000,32'h0,32'h1234_5678,0, 0,1,32'h4000,4'h0,32'h0,32'h1234_5678);
    tbl[5]  = mk(1,0,1,3'b010,32'h4004,32'hCAFE_F00D,32'h0,0, 0,1,32'h4004,4'b1111,32'hCAFE_F00D,32'h0);
    tbl[6]  = mk(0,1,0,3'b010,32'h5000,32'h0,32'h0,0, 0,0,32'h0,4'h0,32'h0,32'h0);
    tbl[7]  = mk(1,1,1,3'b000,32'h5001,32'h0000_00AB,32'h0,1, 0,1,32'h5000,4'b0010,32'h0000_AB00,32'h0);
    tbl[8]  = mk(1,0,1,3'b001,32'h7001,32'h1111,32'h0,0, 1,0,32'h0,4'h0,32'h0,32'h0);
    tbl[9]  = mk(1,0,0,3'b010,32'h7000,32'h0,32'h0,0, 0,0,32'h0,4'h0,32'h0,32'h0);
    tbl[10] = mk(1,1,0,3'b100,32'h8001,32'h0,32'h0000_F000,3, 0,1,32'h8000,4'h0,32'h0,32'h0000_00F0);
    tbl[11] = mk(1,1,0,3'b001,32'h6002,32'h0,32'h8001_7FFF,0, 0,1,32'h6000,4'h0,32'h0,32'hFFFF_8001);
    f3_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    f3_st = '{3'b000, 3'b001, 3'b010};

    rst_n = 1'b0;
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_funct3 = 0;
    mem_alu_out = 0; mem_mem_wdata = 0; dmem_resp = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_be", 32'(dmem_byte_enable), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], (i % 3) == 2);

    // Reset while a request is outstanding, then a stray response.
    @(negedge clk);
    mem_valid = 1; mem_read = 1; mem_write = 0; mem_funct3 = 3'b010;
    mem_alu_out = 32'h9000; dmem_resp = 0;
    #1 chk("rstseq_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1 chk("rstseq_req_read", 32'(dmem_read), 32'd1);
    #2 rst_n = 1'b0; mem_valid = 0;
    #1;
    chk("rstseq_async_read", 32'(dmem_read), 32'd0);
    chk("rstseq_async_addr", dmem_address, 32'h0);
    chk("rstseq_async_load", load_data, 32'h0);
    chk("rstseq_async_stall", 32'(stall), 32'd0);
    @(negedge clk);
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("rstseq_held_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstseq_rel_stall", 32'(stall), 32'd0);
    @(negedge clk);
    dmem_resp = 0;
    #1;
    chk("rstseq_after_load_valid", 32'(load_valid), 32'd0);
    chk("rstseq_after_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rstseq_after_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1 chk("rstseq_late_load_valid", 32'(load_valid), 32'd0);

    for (int k = 0; k < 300; k++) begin
      logic v, rd, wr;
      logic [2:0] f3;
      int sel;
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 3);
      rd  = (sel == 1) || (sel == 3);
      wr  = (sel == 2) || (sel == 3);
      if (rd && !wr) f3 = f3_ld[$urandom_range(0, 4)];
      else           f3 = f3_st[$urandom_range(0, 2)];
      run_vec(model(v, rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
